target_bbox_detect: RTL and testbench
=====================================

TARGET_BBOX_DETECT -- requirements
Module: target_bbox_detect

Interface
REQ-001 Parameters SHALL be: R_MIN, 8'd160, minimum red for a target pixel; G_MAX, 8'd90, maximum green; B_MAX, 8'd90, maximum blue; MIN_PIXELS, 22'd64, minimum matched-pixel count for a valid box; MARGIN, 12'd1, box expansion per side; SYNC_POL, 1'b1, active level of i_vsync.
REQ-002 pixelclk  input  1  pixel clock; all logic on rising edge.
REQ-003 reset_n  input  1  asynchronous, active-low reset.
REQ-004 i_rgb  input  24  pixel, R=[23:16], G=[15:8], B=[7:0].
REQ-005 i_hsync  input  1  line sync; unused except as a pass-through qualifier (not used for counting).
REQ-006 i_vsync  input  1  frame sync, active level SYNC_POL.
REQ-007 i_de  input  1  active-video qualifier.
REQ-008 hcount  output  12  x of the pixel currently on i_rgb.
REQ-009 vcount  output  12  y of the pixel currently on i_rgb.
REQ-010 hcount_l / hcount_r / vcount_l / vcount_r  output  12 each  exclusive window bounds of the last valid box.
REQ-011 o_valid  output  1  last completed frame produced a valid box.
REQ-012 o_pix_cnt  output  22  matched-pixel count of the last completed frame.
REQ-013 o_frame_done  output  1  one-cycle pulse when frame results update.

Function
REQ-014 hcount SHALL increment by 1 on every clock with i_de=1, SHALL clear to 0 on every clock with i_de=0; value during a de cycle equals that pixel's x (first pixel of line = 0).
REQ-015 vcount SHALL increment by 1 on each i_de falling edge (registered i_de=1, i_de=0) and SHALL clear to 0 on frame-start edge; first active line = 0.
REQ-016 Frame-start edge SHALL be the cycle where i_vsync transitions from !SYNC_POL to SYNC_POL (registered previous value).
REQ-017 Pixel match SHALL be i_de=1 AND i_vsync!=SYNC_POL AND R>=R_MIN AND G<=G_MAX AND B<=B_MAX, unsigned compares.
REQ-018 On match, working xmin/xmax/ymin/ymax SHALL update with min/max against (hcount, vcount); working count SHALL increment, saturating at 22'h3FFFFF.
REQ-019 Working registers SHALL be initialised to xmin=ymin=12'hFFF, xmax=ymax=0, count=0 at reset and on every frame-start edge.
REQ-020 On frame-start edge (except first after reset, REQ-025), o_pix_cnt SHALL load working count and o_frame_done SHALL pulse for exactly one cycle, next cycle.
REQ-021 If working count >= MIN_PIXELS at that edge: o_valid<=1; hcount_l<=xmin-MARGIN, vcount_l<=ymin-MARGIN, both saturating at 0; hcount_r<=xmax+MARGIN, vcount_r<=ymax+MARGIN, both saturating at 12'hFFF.
REQ-022 If working count < MIN_PIXELS: o_valid<=0; bound outputs SHALL hold their previous values.
REQ-023 A match on the frame-start-edge cycle is impossible by REQ-017; no pixel SHALL be counted into two frames.
REQ-024 Bound outputs SHALL change only in the cycle following a frame-start edge; stable for the whole subsequent frame.

Reset
REQ-025 During reset_n=0: hcount=vcount=0, bound outputs=0, o_valid=0, o_pix_cnt=0, o_frame_done=0, working registers per REQ-019, vsync history = !SYNC_POL; first frame-start edge after reset SHALL only clear working registers and counters (partial frame discarded, no o_frame_done).
REQ-026 Reset asserted mid-frame SHALL take effect immediately (asynchronous); release SHALL be followed by REQ-025 behaviour.

Verification
REQ-027 Frame 8x8 all black, then frame with red block (255,0,0) at x=2..5, y=3..6 -> after second frame-start edge: o_pix_cnt=16, o_valid=0 (MIN_PIXELS=64), bounds unchanged at 0; with MIN_PIXELS=16: hcount_l=1, hcount_r=6, vcount_l=2, vcount_r=7, o_valid=1.
REQ-028 Single matched pixel at (0,0), MIN_PIXELS=1, MARGIN=1 -> hcount_l=0, vcount_l=0 (saturated), hcount_r=1, vcount_r=1.
REQ-029 Matched pixel at (4095,4095), MARGIN=2, MIN_PIXELS=1 -> hcount_r=vcount_r=12'hFFF, hcount_l=vcount_l=4093.
REQ-030 Pixel (160,90,90) matches; (159,90,90), (160,91,90), (160,90,91) do not -> o_pix_cnt reflects only the first.
REQ-031 Reset pulsed mid-frame after 10 matches, then one full frame with 0 matches -> first edge after release: no o_frame_done; next edge: o_frame_done=1 for one cycle, o_pix_cnt=0, o_valid=0.
REQ-032 Line of 640 de cycles -> hcount sequence 0..639 aligned with pixels, returns 0 on de low; vcount increments once per line.

Source files
------------

// File: rtl/target_bbox_detect_if.sv
// Video-in / box-result bundle for target_bbox_detect.
// master: video source and result consumer (drives i_*, reads results).
// slave : detector (reads i_*, drives coordinates and frame results).
interface target_bbox_detect_if;
   localparam int unsigned PIX_W   = 24;
   localparam int unsigned COORD_W = 12;
   localparam int unsigned CNT_W   = 22;

   logic [PIX_W-1:0]   i_rgb;
   logic               i_hsync;
   logic               i_vsync;
   logic               i_de;
   logic [COORD_W-1:0] hcount;
   logic [COORD_W-1:0] vcount;
   logic [COORD_W-1:0] hcount_l;
   logic [COORD_W-1:0] hcount_r;
   logic [COORD_W-1:0] vcount_l;
   logic [COORD_W-1:0] vcount_r;
   logic               o_valid;
   logic [CNT_W-1:0]   o_pix_cnt;
   logic               o_frame_done;

   modport master (
      output i_rgb, i_hsync, i_vsync, i_de,
      input  hcount, vcount, hcount_l, hcount_r, vcount_l, vcount_r,
             o_valid, o_pix_cnt, o_frame_done
   );

   modport slave (
      input  i_rgb, i_hsync, i_vsync, i_de,
      output hcount, vcount, hcount_l, hcount_r, vcount_l, vcount_r,
             o_valid, o_pix_cnt, o_frame_done
   );
endinterface

// File: rtl/target_bbox_detect.sv
// Colour-target bounding-box detector.
// Tracks pixel x/y from i_de, accumulates the extent and count of pixels
// matching the red-target colour window over a frame, and publishes the
// box (expanded by MARGIN, exclusive bounds) at the next frame-start edge.
// Ports:
//   pixelclk      pixel clock, rising edge
//   reset_n       asynchronous active-low reset
//   vid (slave)   i_rgb/i_hsync/i_vsync/i_de in; hcount/vcount, box bounds,
//                 o_valid, o_pix_cnt, o_frame_done out (all registered)
module target_bbox_detect #(
   parameter logic [7:0]  R_MIN      = 8'd160,
   parameter logic [7:0]  G_MAX      = 8'd90,
   parameter logic [7:0]  B_MAX      = 8'd90,
   parameter logic [21:0] MIN_PIXELS = 22'd64,
   parameter logic [11:0] MARGIN     = 12'd1,
   parameter logic        SYNC_POL   = 1'b1
) (
   input  logic                   pixelclk,
   input  logic                   reset_n,
   target_bbox_detect_if.slave    vid
);
   localparam int unsigned CW = 12;
   localparam int unsigned NW = 22;
   localparam logic [CW-1:0] COORD_MAX = {CW{1'b1}};
   localparam logic [NW-1:0] CNT_MAX   = {NW{1'b1}};

   logic [CW-1:0] xmin_q, xmax_q, ymin_q, ymax_q;
   logic [NW-1:0] cnt_q;
   logic          de_q;
   logic          vsync_q;
   logic          armed_q;

   logic          frame_edge_c;
   logic          match_c;
   logic          box_ok_c;
   logic [CW-1:0] hl_c, hr_c, vl_c, vr_c;
   logic [CW:0]   hsum_c, vsum_c;

   // Line sync carries no information for this block.
   logic unused_hsync;
   assign unused_hsync = vid.i_hsync;

   // Frame edge, pixel classification and margin-expanded box with saturation.
   always_comb begin
      frame_edge_c = (vid.i_vsync == SYNC_POL) && (vsync_q != SYNC_POL);
      match_c      = vid.i_de && (vid.i_vsync != SYNC_POL)
                     && (vid.i_rgb[23:16] >= R_MIN)
                     && (vid.i_rgb[15:8]  <= G_MAX)
                     && (vid.i_rgb[7:0]   <= B_MAX);
      box_ok_c     = (cnt_q >= MIN_PIXELS);
      hl_c         = (xmin_q < MARGIN) ? '0 : CW'(xmin_q - MARGIN);
      vl_c         = (ymin_q < MARGIN) ? '0 : CW'(ymin_q - MARGIN);
      hsum_c       = {1'b0, xmax_q} + {1'b0, MARGIN};
      vsum_c       = {1'b0, ymax_q} + {1'b0, MARGIN};
      hr_c         = hsum_c[CW] ? COORD_MAX : hsum_c[CW-1:0];
      vr_c         = vsum_c[CW] ? COORD_MAX : vsum_c[CW-1:0];
   end

   // Pixel coordinates and sync history.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         vid.hcount <= '0;
         vid.vcount <= '0;
         de_q       <= 1'b0;
         vsync_q    <= ~SYNC_POL;
         armed_q    <= 1'b0;
      end else begin
         de_q       <= vid.i_de;
         vsync_q    <= vid.i_vsync;
         vid.hcount <= vid.i_de ? CW'(vid.hcount + 12'd1) : '0;
         if (frame_edge_c)
            vid.vcount <= '0;
         else if (de_q && !vid.i_de)
            vid.vcount <= CW'(vid.vcount + 12'd1);
         // The first edge after reset only opens a clean frame.
         if (frame_edge_c)
            armed_q <= 1'b1;
      end
   end

   // Working extent and matched-pixel count for the frame in progress.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         xmin_q <= COORD_MAX;
         ymin_q <= COORD_MAX;
         xmax_q <= '0;
         ymax_q <= '0;
         cnt_q  <= '0;
      end else if (frame_edge_c) begin
         xmin_q <= COORD_MAX;
         ymin_q <= COORD_MAX;
         xmax_q <= '0;
         ymax_q <= '0;
         cnt_q  <= '0;
      end else if (match_c) begin
         if (vid.hcount < xmin_q) xmin_q <= vid.hcount;
         if (vid.hcount > xmax_q) xmax_q <= vid.hcount;
         if (vid.vcount < ymin_q) ymin_q <= vid.vcount;
         if (vid.vcount > ymax_q) ymax_q <= vid.vcount;
         if (cnt_q != CNT_MAX)    cnt_q  <= NW'(cnt_q + 22'd1);
      end
   end

   // Frame results; bounds only move when the finished frame held a valid box.
   always_ff @(posedge pixelclk or negedge reset_n) begin
      if (!reset_n) begin
         vid.o_frame_done <= 1'b0;
         vid.o_pix_cnt    <= '0;
         vid.o_valid      <= 1'b0;
         vid.hcount_l     <= '0;
         vid.hcount_r     <= '0;
         vid.vcount_l     <= '0;
         vid.vcount_r     <= '0;
      end else begin
         vid.o_frame_done <= frame_edge_c && armed_q;
         if (frame_edge_c && armed_q) begin
            vid.o_pix_cnt <= cnt_q;
            vid.o_valid   <= box_ok_c;
            if (box_ok_c) begin
               vid.hcount_l <= hl_c;
               vid.hcount_r <= hr_c;
               vid.vcount_l <= vl_c;
               vid.vcount_r <= vr_c;
            end
         end
      end
   end
endmodule

// File: tb/tb_target_bbox_detect.sv
// Scoreboard bench for target_bbox_detect (default parameters).
module tb_target_bbox_detect;
   localparam logic        SP  = 1'b1;
   localparam logic [23:0] RED = 24'hFF0000;

   typedef struct {
      logic [21:0] cnt;
      logic        v;
      logic [11:0] hl, hr, vl, vr;
   } exp_t;

   logic pixelclk = 1'b0;
   logic reset_n  = 1'b0;
   always #5 pixelclk = ~pixelclk;

   target_bbox_detect_if vif ();

   target_bbox_detect dut (
      .pixelclk (pixelclk),
      .reset_n  (reset_n),
      .vid      (vif)
   );

   int   n_cmp = 0;
   int   n_bad = 0;
   exp_t exp_q[$];
   int   hx_q[$];
   int   hy_q[$];
   bit   chk_hv = 1'b0;
   bit   prev_done = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   function automatic logic [23:0] pix(input int pat, input int x, input int y);
      logic [23:0] p;
      p = 24'h000000;
      case (pat)
         1: if (x >= 2 && x <= 5 && y >= 3 && y <= 6) p = RED;
         2: if (x <= 7 && y <= 7) p = RED;
         3: if (y == 0) begin
               if (x == 0) p = 24'hA05A5A;
               if (x == 1) p = 24'h9F5A5A;
               if (x == 2) p = 24'hA05B5A;
               if (x == 3) p = 24'hA05A5B;
            end
         4: if (x >= 5 && x <= 12 && y >= 2 && y <= 9 && !(x == 5 && y == 2)) p = RED;
         5: if (x >= 5 && x <= 12 && y >= 2 && y <= 9) p = RED;
         6: if (y == 0 && x <= 9) p = RED;
         default: p = 24'h000000;
      endcase
      return p;
   endfunction

   task automatic drive(input logic [23:0] rgb, input logic de, input logic vs);
      @(posedge pixelclk);
      #1;
      vif.i_rgb   = rgb;
      vif.i_de    = de;
      vif.i_vsync = vs;
      vif.i_hsync = 1'b0;
   endtask

   task automatic vsync_edge(input bit expect_done, input exp_t e);
      if (expect_done) exp_q.push_back(e);
      repeat (2) drive(24'h0, 1'b0, SP);
      repeat (2) drive(24'h0, 1'b0, ~SP);
   endtask

   task automatic line(input int w, input int y, input int pat);
      for (int x = 0; x < w; x++) begin
         if (chk_hv) begin
            hx_q.push_back(x);
            hy_q.push_back(y);
         end
         drive(pix(pat, x, y), 1'b1, ~SP);
      end
      repeat (2) drive(24'h0, 1'b0, ~SP);
   endtask

   task automatic frame(input int w, input int h, input int pat);
      for (int y = 0; y < h; y++) line(w, y, pat);
   endtask

   // Lines 0..4094 are one black pixel wide; line 4095 spans x=0..4095
   // with red at x=4032..4095.
   task automatic corner_frame();
      for (int y = 0; y < 4095; y++) begin
         drive(24'h0, 1'b1, ~SP);
         drive(24'h0, 1'b0, ~SP);
      end
      for (int x = 0; x < 4096; x++)
         drive((x >= 4032) ? RED : 24'h0, 1'b1, ~SP);
      repeat (2) drive(24'h0, 1'b0, ~SP);
   endtask

   function automatic exp_t mk(input int c, input bit v, input int hl, input int hr,
                               input int vl, input int vr);
      exp_t e;
      e.cnt = 22'(c);
      e.v   = v;
      e.hl  = 12'(hl);
      e.hr  = 12'(hr);
      e.vl  = 12'(vl);
      e.vr  = 12'(vr);
      return e;
   endfunction

   // Monitor: frame results against the scoreboard, coordinates against the driver log.
   always @(negedge pixelclk) begin
      exp_t e;
      if (reset_n) begin
         if (prev_done) chk("done_width", 32'(vif.o_frame_done), 32'd0);
         if (vif.o_frame_done) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_done", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("pix_cnt",  32'(vif.o_pix_cnt), 32'(e.cnt));
               chk("valid",    32'(vif.o_valid),   32'(e.v));
               chk("hcount_l", 32'(vif.hcount_l),  32'(e.hl));
               chk("hcount_r", 32'(vif.hcount_r),  32'(e.hr));
               chk("vcount_l", 32'(vif.vcount_l),  32'(e.vl));
               chk("vcount_r", 32'(vif.vcount_r),  32'(e.vr));
            end
         end
         prev_done = vif.o_frame_done;
         if (chk_hv && vif.i_de) begin
            if (hx_q.size() == 0) begin
               chk("hv_underrun", 32'd1, 32'd0);
            end else begin
               chk("hcount", 32'(vif.hcount), 32'(hx_q.pop_front()));
               chk("vcount", 32'(vif.vcount), 32'(hy_q.pop_front()));
            end
         end
      end else begin
         prev_done = 1'b0;
      end
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      vif.i_rgb   = 24'h0;
      vif.i_de    = 1'b0;
      vif.i_vsync = ~SP;
      vif.i_hsync = 1'b0;
      reset_n     = 1'b0;
      repeat (3) @(posedge pixelclk);
      #1;
      chk("rst_hcount",   32'(vif.hcount),       32'd0);
      chk("rst_vcount",   32'(vif.vcount),       32'd0);
      chk("rst_valid",    32'(vif.o_valid),      32'd0);
      chk("rst_pix_cnt",  32'(vif.o_pix_cnt),    32'd0);
      chk("rst_done",     32'(vif.o_frame_done), 32'd0);
      chk("rst_hcount_r", 32'(vif.hcount_r),     32'd0);
      chk("rst_vcount_r", 32'(vif.vcount_r),     32'd0);
      reset_n = 1'b1;

      // First edge after reset: no result.
      vsync_edge(1'b0, mk(0, 0, 0, 0, 0, 0));
      frame(8, 8, 0);
      vsync_edge(1'b1, mk(0, 0, 0, 0, 0, 0));
      frame(8, 8, 1);                               // 16 px, below threshold
      vsync_edge(1'b1, mk(16, 0, 0, 0, 0, 0));
      frame(10, 10, 2);                             // 64 px at origin
      vsync_edge(1'b1, mk(64, 1, 0, 8, 0, 8));
      frame(8, 8, 3);                               // colour thresholds
      vsync_edge(1'b1, mk(1, 0, 0, 8, 0, 8));
      frame(16, 12, 4);                             // 63 px, one short
      vsync_edge(1'b1, mk(63, 0, 0, 8, 0, 8));
      frame(16, 12, 5);                             // exactly 64 px
      vsync_edge(1'b1, mk(64, 1, 4, 13, 1, 10));
      corner_frame();
      vsync_edge(1'b1, mk(64, 1, 4031, 4095, 4094, 4095));
      chk_hv = 1'b1;
      frame(640, 2, 0);
      chk_hv = 1'b0;
      vsync_edge(1'b1, mk(0, 0, 4031, 4095, 4094, 4095));

      // Reset mid-frame after 10 matches.
      line(10, 0, 6);
      @(posedge pixelclk);
      #1;
      reset_n = 1'b0;
      #1;
      chk("midrst_hcount_l", 32'(vif.hcount_l),  32'd0);
      chk("midrst_hcount_r", 32'(vif.hcount_r),  32'd0);
      chk("midrst_vcount_r", 32'(vif.vcount_r),  32'd0);
      chk("midrst_pix_cnt",  32'(vif.o_pix_cnt), 32'd0);
      repeat (3) @(posedge pixelclk);
      #1;
      reset_n = 1'b1;
      vsync_edge(1'b0, mk(0, 0, 0, 0, 0, 0));
      frame(8, 8, 0);
      vsync_edge(1'b1, mk(0, 0, 0, 0, 0, 0));
      repeat (6) drive(24'h0, 1'b0, ~SP);

      chk("sb_drain", 32'(exp_q.size()), 32'd0);
      chk("hv_drain", 32'(hx_q.size()),  32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
